// File: rtl/nor_chain_sequencer.sv
// nor_chain_sequencer
// Serially evaluates a cascaded NOR chain one stage per clock:
//   s0 = ~(d0 | d1), sk = ~(s(k-1) | d(k+1)).
// A start/busy/done handshake frames each evaluation, and every
// intermediate stage is exposed on 'stages' so the cascade can be
// watched settling one bit at a time.

module nor_chain_sequencer #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  din,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          result,
  output logic [N-2:0]  stages,
  output logic [CW-1:0] stage_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 2);

  state_t         state;
  logic [N-1:0]   din_q;
  logic           acc;
  logic           next_din;
  logic           stage_val;
  logic [N-2:0]   stages_upd;

  // Selects the chain input that feeds the stage being computed this cycle
  // (din_q[stage_idx+1]) without indexing by a wider-than-needed counter.
  always_comb begin
    next_din = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) == stage_idx + CW'(1)) begin
        next_din = din_q[i];
      end
    end
  end

  // Computes the current stage value and the stage vector with that bit written.
  always_comb begin
    stage_val = (stage_idx == '0) ? ~(din_q[0] | din_q[1]) : ~(acc | next_din);
    stages_upd = stages;
    for (int k = 0; k < N - 1; k++) begin
      if (CW'(k) == stage_idx) begin
        stages_upd[k] = stage_val;
      end
    end
  end

  // Sequencer: IDLE accepts start, EVAL walks the chain, FINISH pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 1'b0;
      stages    <= '0;
      stage_idx <= '0;
      acc       <= 1'b0;
      din_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            din_q     <= din;
            stages    <= '0;
            stage_idx <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          acc    <= stage_val;
          stages <= stages_upd;
          if (stage_idx == LAST_IDX) begin
            result    <= stage_val;
            stage_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_FINISH;
          end else begin
            stage_idx <= stage_idx + CW'(1);
          end
        end
        ST_FINISH: begin
          done      <= 1'b0;
          ready     <= 1'b1;
          stage_idx <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          stage_idx <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_chain_sequencer.sv
// tb_nor_chain_sequencer
// Drives directed and random evaluations into nor_chain_sequencer. The
// stimulus side keeps a cycle-level model of the handshake and pushes the
// expected chain result for every accepted start; the monitor compares the
// handshake every cycle and pops one expectation per done pulse.

module tb_nor_chain_sequencer;

  localparam int N  = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [N-2:0] stg;
    logic         res;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  din = '0;
  logic          ready;
  logic          busy;
  logic          done;
  logic          result;
  logic [N-2:0]  stages;
  logic [CW-1:0] stage_idx;

  // Reference model state (written only by the stimulus process).
  int           phase = 0;
  exp_t         cur = '0;
  logic [N-2:0] held_stages = '0;
  logic         held_result = 1'b0;
  logic         accepted = 1'b0;
  int           n_completed = 0;
  bit           stim_done = 1'b0;
  exp_t         exp_q[$];

  // Counters (written only by the monitor process).
  int total = 0;
  int bad = 0;
  int n_done = 0;

  nor_chain_sequencer #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .stages    (stages),
    .stage_idx (stage_idx)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Chain evaluated straight from its definition.
  function automatic exp_t model_chain(input logic [N-1:0] d);
    exp_t e;
    logic s;
    s = ~(d[0] | d[1]);
    e.stg[0] = s;
    for (int k = 1; k <= N - 2; k++) begin
      s = ~(s | d[k+1]);
      e.stg[k] = s;
    end
    e.res = s;
    return e;
  endfunction

  // Advances the handshake model by one clock edge using the driven inputs.
  task automatic model_step();
    accepted = 1'b0;
    if (phase == 0) begin
      if (start) begin
        accepted = 1'b1;
        cur = model_chain(din);
        exp_q.push_back(cur);
        held_stages = '0;
        phase = 1;
      end
    end else if (phase < N) begin
      phase = phase + 1;
      if (phase == N) begin
        held_result = cur.res;
        held_stages = cur.stg;
        n_completed++;
      end
    end else begin
      phase = 0;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [N-1:0] d);
    @(negedge clk);
    start = s;
    din = d;
    @(posedge clk);
    model_step();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    logic [N-1:0] d0;
    int idx;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 4'b0000);
    repeat (N + 2) applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b0001);
    repeat (N + 2) applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b1000);
    repeat (N + 2) applyStimulus(1'b0, 4'b0000);

    idx = 0;
    while (idx < 16) begin
      applyStimulus(1'b1, N'(idx));
      if (accepted) idx++;
    end
    repeat (N + 2) applyStimulus(1'b0, 4'b0000);

    applyStimulus(1'b1, 4'b0110);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b1010);
    repeat (N + 2) applyStimulus(1'b0, 4'b0000);

    d0 = N'($urandom);
    applyStimulus(1'b1, d0);
    repeat (N + 1) applyStimulus(1'b0, N'($urandom));
    repeat (2) applyStimulus(1'b0, 4'b0000);

    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    #3;
    start = 1'b0;
    rst = 1'b1;
    phase = 0;
    held_stages = '0;
    held_result = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b0100);
    repeat (N + 2) applyStimulus(1'b0, 4'b0000);

    repeat (300) applyStimulus(($urandom_range(0, 2) == 0), N'($urandom));
    repeat (N + 3) applyStimulus(1'b0, 4'b0000);
    stim_done = 1'b1;
  end

  // Monitor: per-cycle handshake checks and scoreboard pop on each done.
  initial begin
    exp_t e;
    int m;
    logic [N-2:0] partial;
    while (!stim_done) begin
      @(posedge clk or posedge rst);
      #1;
      if (rst) begin
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_stages", 32'(stages), 32'd0);
        checkOutput("rst_stage_idx", 32'(stage_idx), 32'd0);
      end else begin
        checkOutput("ready", 32'(ready), 32'(phase == 0));
        checkOutput("busy", 32'(busy), 32'(phase >= 1 && phase <= N - 1));
        checkOutput("done", 32'(done), 32'(phase == N));
        checkOutput("stage_idx", 32'(stage_idx),
                    (phase >= 1 && phase <= N - 1) ? 32'(phase - 1) : 32'd0);
        checkOutput("result_hold", 32'(result), 32'(held_result));
        if (phase >= 1 && phase <= N - 1) begin
          m = (1 << (phase - 1)) - 1;
          partial = cur.stg & m[N-2:0];
          checkOutput("stages_partial", 32'(stages), 32'(partial));
        end else begin
          checkOutput("stages_hold", 32'(stages), 32'(held_stages));
        end
        if (done) begin
          n_done++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_result", 32'(result), 32'(e.res));
            checkOutput("sb_stages", 32'(stages), 32'(e.stg));
          end
        end
      end
    end
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("done_count", 32'(n_done), 32'(n_completed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nor_chain_sequencer.md
Name: nor_chain_sequencer

Overview:
- Evaluates an N-input cascaded NOR chain serially, one stage per clock: s0 = ~(d0|d1), sk = ~(s(k-1)|d(k+1)).
- Sits between the lab switch/button inputs and the LED outputs as the sequencing controller for the NOR-cascade datapath.
- Uses a start/busy/done handshake and exposes every intermediate stage, so students can watch the cascade settle stage by stage.

Parameters:
- N, 4, number of chain inputs; legal range 2..16.
- CW, 4, width of stage_idx; must satisfy 2^CW >= N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an evaluation; sampled only in IDLE.
- din  input  N  chain inputs; din[0]=first operand, din[N-1]=last.
- ready  output  1  high in IDLE; start is accepted in this state.
- busy  output  1  high while the chain is being evaluated (EVAL).
- done  output  1  single-cycle pulse when the final stage is valid.
- result  output  1  final stage value s(N-2); held until the next accepted start.
- stages  output  N-1  stages[k] = sk; cleared on start, filled one bit per EVAL cycle.
- stage_idx  output  CW  index of the stage computed in the current EVAL cycle; 0 outside EVAL.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; stages=0, result=0, done=0, busy=0, stage_idx=0, internal acc=0, din_q=0.
  - ready=1 while in IDLE, including during reset.
- States: IDLE, EVAL, DONE. All outputs are registered, or decoded from state only.
- IDLE:
  - ready=1.
  - On an edge with start=1: din_q<=din, stages<=0, stage_idx<=0, go to EVAL.
  - start=0: stay in IDLE, all outputs hold.
- EVAL (busy=1, ready=0), each edge:
  - stage_idx==0: acc<=~(din_q[0]|din_q[1]).
  - Otherwise: acc<=~(acc|din_q[stage_idx+1]).
  - stages[stage_idx] is written with the same value.
  - If stage_idx==N-2: result<=the value computed this cycle, go to DONE. Otherwise stage_idx<=stage_idx+1.
- DONE:
  - done=1 for exactly one cycle; busy=0, ready=0.
  - Next edge goes to IDLE unconditionally; stage_idx<=0.
- Latency:
  - start high in cycle 0, accepted at the end of cycle 0.
  - busy high in cycles 1..N-1 (N-1 cycles).
  - done high in cycle N.
  - ready high again in cycle N+1. For N=4: done in cycle 4.
- Boundary conditions:
  - start while EVAL or DONE: ignored, no queueing.
  - start held continuously: re-accepted in the first IDLE cycle, giving one evaluation every N+1 cycles.
  - din changes after acceptance: no effect; only din_q is used.
  - N=2: a single EVAL cycle; stages is 1 bit; done in cycle 2.
  - rst asserted mid-EVAL: immediate abort to the reset values; no done pulse.
  - result and stages hold their last values through IDLE until the next accepted start. stages clears on start; result updates only at the final stage.

Test Plan:
- N=4, din=4'b0000, start pulse in cycle 0 -> stages go 3'b001, 3'b001, 3'b101 over cycles 1..3 (stages[1]=0 at cycle 2); final stages=3'b101, result=1, done=1 only in cycle 4, ready=1 in cycle 5.
- N=4, din=4'b0001 -> stages=3'b010, result=0. din=4'b1000 -> stages=3'b001, result=0.
- N=4, exhaustive din=0..15, back-to-back with start held high -> each run matches e=~(a|b), f=~(e|c), g=~(f|d); one done every 5 cycles; result=g.
- N=4, start pulsed again in cycles 2 and 4 during a run -> ignored: exactly one done, stage_idx sequence 0,1,2, no extra busy cycles.
- N=4, din toggled every cycle after acceptance -> result equals the value computed from din sampled at the start edge.
- N=4, rst pulsed asynchronously mid-cycle 2 -> outputs zero immediately, ready=1, no done pulse; the next start completes normally.
